// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage types and constants: the fetch FSM encoding, datapath
// widths, and the opcode values that decode already uses.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } fetch_state_e;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

endpackage

// File: rtl/pc_target_calc.sv
// MIPS-style redirect target arithmetic: the branch target is relative to
// base+4, and the jump target keeps the upper nibble of base+4.
module pc_target_calc
  import pc_fetch_pkg::*;
(
  input  logic [31:0] base_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] index_i,
  input  logic        jump_i,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  logic [31:0] seq_pc;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;

  assign seq_pc       = base_i + PC_INC;
  assign branch_tgt   = seq_pc + {{14{imm_i[15]}}, imm_i, 2'b00};
  assign jump_tgt     = {seq_pc[31:28], index_i, 2'b00};
  assign target_o     = jump_i ? jump_tgt : branch_tgt;
  assign misaligned_o = |target_o[1:0];

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational
// instruction memory into a valid/ready instruction register, applies redirects.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_req,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [31:0]        ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redir_valid,
  input  logic               redir_jump,
  input  logic [31:0]        redir_base,
  input  logic [15:0]        redir_imm,
  input  logic [25:0]        redir_index,
  output logic [31:0]        pc,
  output logic               halted,
  output logic               fault
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [31:0]        ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;

  logic [31:0] redir_target;
  logic        redir_misaligned;
  logic        advance;

  pc_target_calc u_target (
    .base_i       (redir_base),
    .imm_i        (redir_imm),
    .index_i      (redir_index),
    .jump_i       (redir_jump),
    .target_o     (redir_target),
    .misaligned_o (redir_misaligned)
  );

  assign advance = (!ir_valid_q || ir_ready) && !redir_valid;

  // Consumption clears ir_valid in every state; only RUN can refill it.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q && !ir_ready;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (redir_valid) begin
          ir_valid_d = 1'b0;
          if (redir_misaligned) state_d = ST_FAULT;
          else                  pc_d    = redir_target;
        end else if (advance) begin
          if (pc_q > LAST_PC) begin
            state_d = ST_FAULT;
          end else begin
            ir_d       = imem_rdata;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + PC_INC;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign halted    = (state_q == ST_HALT);
  assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: one instance from address 0, one starting at
// the last legal word to exercise the end-of-memory fault.
module tb_pc_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // DUT A (RESET_PC = 0)
  logic        reset = 1'b0, start = 1'b0, halt_req = 1'b0, ir_ready = 1'b1;
  logic        redir_valid = 1'b0, redir_jump = 1'b0;
  logic [31:0] redir_base = '0;
  logic [15:0] redir_imm = '0;
  logic [25:0] redir_index = '0;
  logic [31:0] imem_addr, imem_rdata, ir, ir_pc, pc;
  logic        ir_valid, halted, fault;

  // DUT B (RESET_PC = 252)
  logic        b_reset = 1'b0, b_start = 1'b0, b_halt = 1'b0, b_ready = 1'b1;
  logic        b_rv = 1'b0, b_rj = 1'b0;
  logic [31:0] b_rbase = '0;
  logic [15:0] b_rimm = '0;
  logic [25:0] b_ridx = '0;
  logic [31:0] b_addr, b_rdata, b_ir, b_ir_pc, b_pc;
  logic        b_ir_valid, b_halted, b_fault;

  // Memory image: 0x8FE10001 at address 0, elsewhere 0xA0000000 | address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a == 32'd0) ? 32'h8FE1_0001 : (32'hA000_0000 | a);
  endfunction

  assign imem_rdata = word_at(imem_addr);
  assign b_rdata    = word_at(b_addr);

  pc_fetch #(.RESET_PC(32'h0000_0000), .MEM_BYTES(256)) dut_a (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redir_valid(redir_valid), .redir_jump(redir_jump), .redir_base(redir_base),
    .redir_imm(redir_imm), .redir_index(redir_index),
    .pc(pc), .halted(halted), .fault(fault)
  );

  pc_fetch #(.RESET_PC(32'd252), .MEM_BYTES(256)) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .halt_req(b_halt),
    .imem_addr(b_addr), .imem_rdata(b_rdata),
    .ir(b_ir), .ir_pc(b_ir_pc), .ir_valid(b_ir_valid), .ir_ready(b_ready),
    .redir_valid(b_rv), .redir_jump(b_rj), .redir_base(b_rbase),
    .redir_imm(b_rimm), .redir_index(b_ridx),
    .pc(b_pc), .halted(b_halted), .fault(b_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; b_reset = 1'b1;
    tick(); tick();
    reset = 1'b0; b_reset = 1'b0;
    vectors++; if (pc !== 32'd0) begin miscompares++; $display("FAIL reset_pc got %h want %h", pc, 32'd0); end
    vectors++; if (ir !== 32'd0) begin miscompares++; $display("FAIL reset_ir got %h want %h", ir, 32'd0); end
    vectors++; if (ir_pc !== 32'd0) begin miscompares++; $display("FAIL reset_ir_pc got %h want %h", ir_pc, 32'd0); end
    vectors++; if ({ir_valid, halted, fault} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {ir_valid, halted, fault}); end
    vectors++; if (b_pc !== 32'd252) begin miscompares++; $display("FAIL reset_pc_b got %h want %h", b_pc, 32'd252); end
    tick();
    vectors++; if (pc !== 32'd0 || ir_valid !== 1'b0) begin miscompares++; $display("FAIL idle_nofetch pc %h v %b want 0 0", pc, ir_valid); end
  endtask

  task automatic test_fetch();
    start = 1'b1; ir_ready = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (pc !== 32'd0 || ir_valid !== 1'b0) begin miscompares++; $display("FAIL start_run pc %h v %b want 0 0", pc, ir_valid); end
    tick();
    vectors++; if (ir !== 32'h8FE1_0001) begin miscompares++; $display("FAIL fetch0_ir got %h want %h", ir, 32'h8FE1_0001); end
    vectors++; if (ir_pc !== 32'd0 || ir_valid !== 1'b1) begin miscompares++; $display("FAIL fetch0_irpc got %h v %b want 0 1", ir_pc, ir_valid); end
    vectors++; if (pc !== 32'd4 || imem_addr !== 32'd4) begin miscompares++; $display("FAIL fetch0_pc got %h addr %h want 4", pc, imem_addr); end
    tick();
    vectors++; if (ir_pc !== 32'd4 || pc !== 32'd8 || ir !== 32'hA000_0004) begin miscompares++; $display("FAIL fetch1 ir_pc %h pc %h ir %h want 4 8 a0000004", ir_pc, pc, ir); end
  endtask

  task automatic test_backpressure();
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (ir_pc !== 32'd4 || pc !== 32'd8 || ir !== 32'hA000_0004 || ir_valid !== 1'b1) begin
        miscompares++; $display("FAIL stall%0d ir_pc %h pc %h ir %h v %b want 4 8 a0000004 1", i, ir_pc, pc, ir, ir_valid);
      end
    end
    ir_ready = 1'b1;
    tick();
    vectors++; if (ir_pc !== 32'd8 || pc !== 32'd12) begin miscompares++; $display("FAIL release ir_pc %h pc %h want 8 c", ir_pc, pc); end
  endtask

  task automatic test_branch();
    redir_valid = 1'b1; redir_jump = 1'b0; redir_base = 32'd24; redir_imm = 16'd1;
    tick();
    redir_valid = 1'b0;
    vectors++; if (pc !== 32'd32 || ir_valid !== 1'b0) begin miscompares++; $display("FAIL branch pc %h v %b want 20 0", pc, ir_valid); end
    tick();
    vectors++; if (ir_pc !== 32'd32 || ir !== 32'hA000_0020 || pc !== 32'd36) begin miscompares++; $display("FAIL branch_fetch ir_pc %h ir %h pc %h want 20 a0000020 24", ir_pc, ir, pc); end
  endtask

  task automatic test_jump();
    redir_valid = 1'b1; redir_jump = 1'b1; redir_base = 32'd28; redir_index = 26'd4;
    tick();
    vectors++; if (pc !== 32'd16 || ir_valid !== 1'b0) begin miscompares++; $display("FAIL jump pc %h v %b want 10 0", pc, ir_valid); end
    redir_jump = 1'b0; redir_base = 32'd24; redir_imm = 16'hFFFE;
    tick();
    redir_valid = 1'b0;
    vectors++; if (pc !== 32'd20 || ir_valid !== 1'b0) begin miscompares++; $display("FAIL back_branch pc %h v %b want 14 0", pc, ir_valid); end
    tick();
    vectors++; if (ir_pc !== 32'd20 || pc !== 32'd24) begin miscompares++; $display("FAIL back_fetch ir_pc %h pc %h want 14 18", ir_pc, pc); end
  endtask

  task automatic test_halt();
    halt_req = 1'b1; redir_valid = 1'b1; redir_jump = 1'b0; redir_base = 32'd24; redir_imm = 16'd1;
    tick();
    halt_req = 1'b0; redir_valid = 1'b0;
    vectors++; if (halted !== 1'b1 || pc !== 32'd24) begin miscompares++; $display("FAIL halt_wins halted %b pc %h want 1 18", halted, pc); end
    vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL halt_consume got %b want 0", ir_valid); end
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    vectors++; if (pc !== 32'd24 || halted !== 1'b1 || fault !== 1'b0 || ir_pc !== 32'd20) begin
      miscompares++; $display("FAIL halt_frozen pc %h h %b f %b ir_pc %h want 18 1 0 14", pc, halted, fault, ir_pc);
    end
  endtask

  task automatic test_reset_mid_run();
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    ir_ready = 1'b0;
    tick();
    vectors++; if (ir_valid !== 1'b1 || pc !== 32'd4) begin miscompares++; $display("FAIL pre_reset v %b pc %h want 1 4", ir_valid, pc); end
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    vectors++; if (pc !== 32'd0 || ir_valid !== 1'b0 || ir !== 32'd0 || halted !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset pc %h v %b ir %h h %b want 0 0 0 0", pc, ir_valid, ir, halted);
    end
    ir_ready = 1'b1;
    tick();
    vectors++; if (pc !== 32'd0 || ir_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_idle pc %h v %b want 0 0", pc, ir_valid); end
  endtask

  task automatic test_fault_redirect();
    start = 1'b1; tick(); start = 1'b0;
    redir_valid = 1'b1; redir_jump = 1'b0; redir_base = 32'd14; redir_imm = 16'd0;
    tick();
    redir_valid = 1'b0;
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL misalign_fault got %b want 1", fault); end
    tick();
    vectors++; if (fault !== 1'b1 || pc !== 32'd0 || ir_valid !== 1'b0) begin miscompares++; $display("FAIL fault_absorb f %b pc %h v %b want 1 0 0", fault, pc, ir_valid); end
  endtask

  task automatic test_fault_end();
    b_start = 1'b1; b_ready = 1'b1;
    tick();
    b_start = 1'b0;
    vectors++; if (b_pc !== 32'd252 || b_ir_valid !== 1'b0) begin miscompares++; $display("FAIL end_start pc %h v %b want fc 0", b_pc, b_ir_valid); end
    tick();
    vectors++; if (b_ir !== 32'hA000_00FC || b_ir_pc !== 32'd252 || b_pc !== 32'd256 || b_fault !== 1'b0) begin
      miscompares++; $display("FAIL end_fetch ir %h ir_pc %h pc %h f %b want a00000fc fc 100 0", b_ir, b_ir_pc, b_pc, b_fault);
    end
    tick();
    vectors++; if (b_fault !== 1'b1 || b_pc !== 32'd256 || b_ir_pc !== 32'd252 || b_ir_valid !== 1'b0) begin
      miscompares++; $display("FAIL end_fault f %b pc %h ir_pc %h v %b want 1 100 fc 0", b_fault, b_pc, b_ir_pc, b_ir_valid);
    end
    tick();
    vectors++; if (b_fault !== 1'b1 || b_pc !== 32'd256 || b_ir !== 32'hA000_00FC) begin
      miscompares++; $display("FAIL end_hold f %b pc %h ir %h want 1 100 a00000fc", b_fault, b_pc, b_ir);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_branch();
    test_jump();
    test_halt();
    test_reset_mid_run();
    test_fault_redirect();
    test_fault_end();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
